uart_rx_core: RTL and testbench

Parametrised successor to the current UART receive block. Supports 5-9 data bits, even/odd/mark/space parity, 1 or 2 stop bits, and a configurable oversampling ratio. Each bit is decided by a 3-sample majority vote, and breaks and framing errors are detected. Each received character, with its status, is presented on a one-entry valid/ready output register. It sits between the Rx input synchroniser/baud generator and the UART register/FIFO layer.

---
 rtl/uart_rx_core_pkg.sv | 35 +++
 rtl/uart_rx_voter.sv | 36 +++
 rtl/uart_rx_core.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared types and constants for the UART receive core: FSM states, parity modes and
// rx_conf_i field layout.
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } rx_state_e;

  typedef enum logic [1:0] {
    ParNone  = 2'b00,
    ParEven  = 2'b01,
    ParOdd   = 2'b10,
    ParStick = 2'b11
  } parity_mode_e;

  localparam int unsigned ConfDataSelLsb = 0;
  localparam int unsigned ConfStop2Bit   = 3;
  localparam int unsigned ConfParityLsb  = 4;

  // Index of the last data bit (data bits - 1), clamped to the data register width.
  function automatic logic [3:0] last_bit_idx(input logic [2:0] data_sel,
                                              input int unsigned max_data_w);
    logic [3:0] idx;
    logic [3:0] lim;
    idx = 4'd4 + {1'b0, data_sel};
    lim = 4'(max_data_w - 1);
    return (idx > lim) ? lim : idx;
  endfunction

endpackage

// File: rtl/uart_rx_voter.sv
// Three-sample majority voter: captures the line at MID-1 and MID, decides at MID+1.
module uart_rx_voter #(
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned SAMPLE_COUNT_W = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      baud_en_i,
  input  logic                      uart_rx_i,
  input  logic [SAMPLE_COUNT_W-1:0] sample_cnt_i,
  output logic                      vote_valid_o,
  output logic                      vote_bit_o
);

  localparam logic [SAMPLE_COUNT_W-1:0] MidM1 = SAMPLE_COUNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_COUNT_W-1:0] Mid   = SAMPLE_COUNT_W'(OVERSAMPLE / 2);
  localparam logic [SAMPLE_COUNT_W-1:0] MidP1 = SAMPLE_COUNT_W'(OVERSAMPLE / 2 + 1);

  logic s0_q, s1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else if (baud_en_i) begin
      if (sample_cnt_i == MidM1) s0_q <= uart_rx_i;
      if (sample_cnt_i == Mid)   s1_q <= uart_rx_i;
    end
  end

  always_comb begin
    vote_valid_o = baud_en_i && (sample_cnt_i == MidP1);
    vote_bit_o   = (s0_q & s1_q) | (s0_q & uart_rx_i) | (s1_q & uart_rx_i);
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: oversampled start detection, majority-voted bits, parity/frame/break
// status and a one-entry valid/ready output register with overrun reporting.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned MAX_DATA_W     = 9,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned SAMPLE_COUNT_W = 4,
  parameter int unsigned CONF_W         = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  baud_en_i,
  input  logic                  rx_en_i,
  input  logic                  uart_rx_i,
  input  logic [CONF_W-1:0]     rx_conf_i,
  input  logic                  rx_ready_i,
  output logic                  rx_valid_o,
  output logic [MAX_DATA_W-1:0] rx_data_o,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_break_o,
  output logic                  rx_overrun_o,
  output logic                  rx_busy_o
);

  rx_state_e                 state_q, state_d;
  parity_mode_e              par_mode_q, par_mode_d;
  logic [SAMPLE_COUNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]                bit_idx_q, bit_idx_d, last_idx_q, last_idx_d;
  logic                      stop2_q, stop2_d, stop_idx_q, stop_idx_d;
  logic [MAX_DATA_W-1:0]     shift_q, shift_d;
  logic                      par_bit_q, par_bit_d, frame_err_q, frame_err_d;
  logic                      vote_valid, vote_bit, commit, cnt_last;
  logic                      char_brk, char_perr, par_calc;

  logic                      out_valid_q, out_valid_d, ovr_q, ovr_d;
  logic [MAX_DATA_W-1:0]     out_data_q, out_data_d;
  logic                      out_perr_q, out_perr_d, out_ferr_q, out_ferr_d;
  logic                      out_brk_q, out_brk_d;

  uart_rx_voter #(
    .OVERSAMPLE    (OVERSAMPLE),
    .SAMPLE_COUNT_W(SAMPLE_COUNT_W)
  ) u_voter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .baud_en_i   (baud_en_i),
    .uart_rx_i   (uart_rx_i),
    .sample_cnt_i(cnt_q),
    .vote_valid_o(vote_valid),
    .vote_bit_o  (vote_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      par_mode_q  <= ParNone;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      last_idx_q  <= '0;
      stop2_q     <= 1'b0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      par_mode_q  <= par_mode_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      last_idx_q  <= last_idx_d;
      stop2_q     <= stop2_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    par_mode_d  = par_mode_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    last_idx_d  = last_idx_q;
    stop2_d     = stop2_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    frame_err_d = frame_err_q;
    commit      = 1'b0;
    cnt_last    = (cnt_q == SAMPLE_COUNT_W'(OVERSAMPLE - 1));
    if (baud_en_i) begin
      if (state_q != StIdle && !rx_en_i) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_last ? '0 : cnt_q + SAMPLE_COUNT_W'(1);
        unique case (state_q)
          StIdle: begin
            cnt_d = '0;
            if (rx_en_i && !uart_rx_i) begin
              par_mode_d  = parity_mode_e'(rx_conf_i[ConfParityLsb +: 2]);
              stop2_d     = rx_conf_i[ConfStop2Bit];
              last_idx_d  = last_bit_idx(rx_conf_i[ConfDataSelLsb +: 3], MAX_DATA_W);
              bit_idx_d   = '0;
              stop_idx_d  = 1'b0;
              shift_d     = '0;
              par_bit_d   = 1'b0;
              frame_err_d = 1'b0;
              state_d     = StStart;
            end
          end
          StStart: begin
            if (vote_valid && vote_bit) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else if (cnt_last) begin
              state_d = StData;
            end
          end
          StData: begin
            if (vote_valid) begin
              for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
                if (bit_idx_q == 4'(i)) shift_d[i] = vote_bit;
              end
            end
            if (cnt_last) begin
              if (bit_idx_q == last_idx_q) begin
                state_d = (par_mode_q == ParNone) ? StStop : StParity;
              end else begin
                bit_idx_d = bit_idx_q + 4'd1;
              end
            end
          end
          StParity: begin
            if (vote_valid) par_bit_d = vote_bit;
            if (cnt_last) state_d = StStop;
          end
          StStop: begin
            if (vote_valid) begin
              if (!vote_bit) frame_err_d = 1'b1;
              // Commit at mid-bit of the last stop bit so the next start edge is not missed.
              if (stop_idx_q == stop2_q) begin
                commit  = 1'b1;
                state_d = vote_bit ? StIdle : StWaitHigh;
              end
            end else if (cnt_last) begin
              stop_idx_d = 1'b1;
            end
          end
          StWaitHigh: begin
            if (uart_rx_i) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    rx_busy_o = state_q inside {StStart, StData, StParity, StStop};
    par_calc  = (^shift_q) ^ par_bit_q;
    char_brk  = (shift_q == '0) && (par_mode_q == ParNone || !par_bit_q) && frame_err_d;
    unique case (par_mode_q)
      ParNone:  char_perr = 1'b0;
      ParEven:  char_perr = par_calc;
      ParOdd:   char_perr = ~par_calc;
      ParStick: char_perr = par_bit_q ^ ~last_idx_q[0];
      default:  char_perr = 1'b0;
    endcase
    if (char_brk) char_perr = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    out_brk_d   = out_brk_q;
    ovr_d       = 1'b0;
    if (commit) begin
      if (!out_valid_q || rx_ready_i) begin
        out_valid_d = 1'b1;
        out_data_d  = shift_q;
        out_perr_d  = char_perr;
        out_ferr_d  = frame_err_d;
        out_brk_d   = char_brk;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (out_valid_q && rx_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      out_brk_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
      out_brk_q   <= out_brk_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rx_valid_o      = out_valid_q;
  assign rx_data_o       = out_data_q;
  assign rx_parity_err_o = out_perr_q;
  assign rx_frame_err_o  = out_ferr_q;
  assign rx_break_o      = out_brk_q;
  assign rx_overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected characters, a negedge
// monitor pops and compares on every valid/ready handshake.
module tb_uart_rx_core;

  localparam int OS = 16;
  localparam logic [5:0] Conf8N1 = 6'b00_0_011;
  localparam logic [5:0] Conf7E2 = 6'b01_1_010;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, baud_en, rx_en, uart_rx, ready;
  logic [5:0] conf;
  logic       valid, perr, ferr, brk, ovr, busy;
  logic [8:0] data;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;
  int   hs_cnt = 0;
  int   ovr_cnt = 0;
  logic valid_prev = 1'b0;

  uart_rx_core dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .baud_en_i      (baud_en),
    .rx_en_i        (rx_en),
    .uart_rx_i      (uart_rx),
    .rx_conf_i      (conf),
    .rx_ready_i     (ready),
    .rx_valid_o     (valid),
    .rx_data_o      (data),
    .rx_parity_err_o(perr),
    .rx_frame_err_o (ferr),
    .rx_break_o     (brk),
    .rx_overrun_o   (ovr),
    .rx_busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    e.brk  = bk;
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
  task automatic drive(input logic b, input int n);
    uart_rx = b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input bit has_par,
                            input logic par, input int nstop, input int gap);
    start_cyc = cyc + 1;
    drive(1'b0, OS);
    for (int i = 0; i < nbits; i++) drive(d[i], OS);
    if (has_par) drive(par, OS);
    drive(1'b1, OS * nstop + gap);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid && !valid_prev) rise_cyc = cyc;
        valid_prev = valid;
        if (ovr) ovr_cnt++;
        if (valid && ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char: got data %0h with no character expected", data);
          end else begin
            e = exp_q.pop_front();
            chk("char_data", 32'(data), 32'(e.data));
            chk("char_parity_err", 32'(perr), 32'(e.perr));
            chk("char_frame_err", 32'(ferr), 32'(e.ferr));
            chk("char_break", 32'(brk), 32'(e.brk));
          end
        end
      end else begin
        valid_prev = 1'b0;
      end
    end
  end

  initial begin
    int bcnt;
    int hs0;
    int ovr0;
    rst_n   = 1'b0;
    baud_en = 1'b1;
    rx_en   = 1'b1;
    uart_rx = 1'b1;
    ready   = 1'b1;
    conf    = Conf8N1;
    #1;
    chk("reset_valid", 32'(valid), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_perr", 32'(perr), 0);
    chk("reset_ferr", 32'(ferr), 0);
    chk("reset_break", 32'(brk), 0);
    chk("reset_overrun", 32'(ovr), 0);
    chk("reset_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 20);

    // 8N1 0xA5; commit lands at mid-point of the stop bit (bit 9): 9*16 + 10 ticks
    push(9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 20);
    chk("a5_latency", 32'(rise_cyc - start_cyc), 32'd154);

    // 7E2 0x41 (two ones): parity bit 1 is wrong, 0 is right
    conf = Conf7E2;
    push(9'h041, 1'b1, 1'b0, 1'b0);
    send_frame(9'h041, 7, 1'b1, 1'b1, 2, 20);
    push(9'h041, 1'b0, 1'b0, 1'b0);
    send_frame(9'h041, 7, 1'b1, 1'b0, 2, 20);

    // One-tick glitch: busy from start detect until the MID+1 vote rejects it
    conf = Conf8N1;
    hs0  = hs_cnt;
    bcnt = 0;
    uart_rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) uart_rx = 1'b1;
      if (busy) bcnt++;
    end
    chk("glitch_busy_cycles", 32'(bcnt), 32'd10);
    chk("glitch_no_char", 32'(hs_cnt - hs0), 0);
    chk("glitch_busy_end", 32'(busy), 0);

    // Break: 20 bit times low, then 0x3C only after the line returns high
    push(9'h000, 1'b0, 1'b1, 1'b1);
    uart_rx = 1'b0;
    for (int i = 0; i < 20 * OS; i++) begin
      @(posedge clk);
      #2;
      if (i == 250) chk("break_no_restart", 32'(busy), 0);
    end
    drive(1'b1, 20);
    push(9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 20);

    // Back-to-back with ready low: 0x11 held, 0x22 overruns
    ready = 1'b0;
    ovr0  = ovr_cnt;
    push(9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 0);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 20);
    chk("overrun_pulses", 32'(ovr_cnt - ovr0), 1);
    chk("held_valid", 32'(valid), 1);
    chk("held_data", 32'(data), 32'h11);
    ready = 1'b1;
    drive(1'b1, 5);

    // rx_en dropped in data bit 3 of 0x55: abort with no character
    hs0 = hs_cnt;
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b0, 8);
    chk("abort_busy_before", 32'(busy), 1);
    rx_en = 1'b0;
    drive(1'b0, 2);
    chk("abort_busy_after", 32'(busy), 0);
    drive(1'b0, 6);
    drive(1'b1, OS);
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b0, OS);
    drive(1'b1, 36);
    rx_en = 1'b1;
    drive(1'b1, 4);
    chk("abort_no_char", 32'(hs_cnt - hs0), 0);
    chk("abort_valid", 32'(valid), 0);

    // Asynchronous reset mid-frame with a character held
    ready = 1'b0;
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 20);
    chk("pre_reset_valid", 32'(valid), 1);
    chk("pre_reset_data", 32'(data), 32'h5A);
    drive(1'b0, OS);
    drive(1'b1, OS + 5);
    chk("pre_reset_busy", 32'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(valid), 0);
    chk("midreset_data", 32'(data), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_overrun", 32'(ovr), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready = 1'b1;
    drive(1'b1, 20);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
